// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and fetch handshake controller.
// Selects the next PC (redirect, pending redirect or sequential PC_Next),
// holds it across memory waits and stalls, and halts on a misaligned target.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_Next,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Stall,
  input  logic        IMem_Ready,
  output logic [31:0] PC,
  output logic        IMem_Req,
  output logic        Fetch_Done,
  output logic        Trap_Misaligned,
  output logic [31:0] Fetch_Count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        fetch_done_q, fetch_done_d;
  logic        trap_q, trap_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        imem_req_s;
  logic        hs_s;
  logic [31:0] sel_pc_s;

  // Next-state, request and next-PC selection logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    fetch_done_d  = 1'b0;
    trap_d        = trap_q;
    fetch_count_d = fetch_count_q;
    imem_req_s    = 1'b0;
    hs_s          = 1'b0;

    // A redirect seen this cycle wins over an older pending one.
    if (Redirect_Valid) begin
      sel_pc_s = Redirect_Target;
    end else if (pend_valid_q) begin
      sel_pc_s = pend_target_q;
    end else begin
      sel_pc_s = PC_Next;
    end

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (Redirect_Valid) begin
          pend_valid_d  = 1'b1;
          pend_target_d = Redirect_Target;
        end else begin
          pend_valid_d  = pend_valid_q;
        end
      end
      FETCH: begin
        imem_req_s = ~Stall;
        hs_s       = imem_req_s & IMem_Ready;
        if (hs_s) begin
          fetch_done_d  = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          pend_valid_d  = 1'b0;
          // A misaligned target freezes the PC and parks the FSM for good.
          if (sel_pc_s[1:0] != 2'b00) begin
            state_d = HALT;
            trap_d  = 1'b1;
          end else begin
            pc_d    = sel_pc_s;
          end
        end else if (Redirect_Valid) begin
          pend_valid_d  = 1'b1;
          pend_target_d = Redirect_Target;
        end else begin
          pend_valid_d  = pend_valid_q;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      fetch_done_q  <= 1'b0;
      trap_q        <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fetch_done_q  <= fetch_done_d;
      trap_q        <= trap_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign PC              = pc_q;
  assign IMem_Req        = imem_req_s;
  assign Fetch_Done      = fetch_done_q;
  assign Trap_Misaligned = trap_q;
  assign Fetch_Count     = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and randomized checks of pc_fetch_ctrl against
// a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_Next;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Stall;
  logic        IMem_Ready;
  logic [31:0] PC;
  logic        IMem_Req;
  logic        Fetch_Done;
  logic        Trap_Misaligned;
  logic [31:0] Fetch_Count;

  int n_vec;
  int n_err;

  // Behavioural model state.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_halt;
  bit          m_pend;
  logic [31:0] m_pt;
  logic [31:0] m_cnt;
  bit          m_done;
  bit          m_trap;

  pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PC_Next         (PC_Next),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .Stall           (Stall),
    .IMem_Ready      (IMem_Ready),
    .PC              (PC),
    .IMem_Req        (IMem_Req),
    .Fetch_Done      (Fetch_Done),
    .Trap_Misaligned (Trap_Misaligned),
    .Fetch_Count     (Fetch_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_boot = 1'b1; m_halt = 1'b0; m_pend = 1'b0; m_pt = 32'h0;
    m_cnt = 32'h0; m_done = 1'b0; m_trap = 1'b0;
  endtask

  function automatic bit model_req();
    return !m_halt && !m_boot && !Stall;
  endfunction

  // One rising edge of the reference model, from the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt;
    m_done = 1'b0;
    if (m_halt) begin
      // terminal: nothing changes
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (Redirect_Valid) begin m_pend = 1'b1; m_pt = Redirect_Target; end
    end else if (model_req() && IMem_Ready) begin
      tgt = Redirect_Valid ? Redirect_Target : (m_pend ? m_pt : PC_Next);
      m_pend = 1'b0;
      m_cnt  = m_cnt + 32'd1;
      m_done = 1'b1;
      if (tgt % 4 != 0) begin m_halt = 1'b1; m_trap = 1'b1; end
      else m_pc = tgt;
    end else if (Redirect_Valid) begin
      m_pend = 1'b1; m_pt = Redirect_Target;
    end
  endtask

  task automatic chk_reset();
    chk("rst_pc",    PC,                     RV);
    chk("rst_req",   {31'd0, IMem_Req},      32'd0);
    chk("rst_done",  {31'd0, Fetch_Done},    32'd0);
    chk("rst_trap",  {31'd0, Trap_Misaligned}, 32'd0);
    chk("rst_count", Fetch_Count,            32'd0);
  endtask

  // Apply inputs for one cycle, check the request mid-cycle and the
  // registered outputs just after the rising edge.
  task automatic cycle(input bit st, input bit rd, input bit rv,
                       input logic [31:0] rt, input logic [31:0] pn);
    Stall = st; IMem_Ready = rd; Redirect_Valid = rv; Redirect_Target = rt;
    PC_Next = pn;
    @(negedge clk);
    chk("imem_req", {31'd0, IMem_Req}, {31'd0, model_req()});
    @(posedge clk);
    model_step();
    #1;
    chk("pc",    PC,                         m_pc);
    chk("done",  {31'd0, Fetch_Done},        {31'd0, m_done});
    chk("trap",  {31'd0, Trap_Misaligned},   {31'd0, m_trap});
    chk("count", Fetch_Count,                m_cnt);
  endtask

  task automatic seq(input bit st, input bit rd, input bit rv, input logic [31:0] rt);
    cycle(st, rd, rv, rt, m_pc + 32'd4);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; Stall = 1'b0; IMem_Ready = 1'b0; Redirect_Valid = 1'b0;
    Redirect_Target = 32'h0; PC_Next = 32'h4;
    model_reset();
    #12;
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot cycle, then three sequential fetches 0 -> 4 -> 8 -> C.
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("boot_pc", PC, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("seq_pc",    PC,          32'hC);
    chk("seq_count", Fetch_Count, 32'd3);

    // Memory wait for three cycles, then accept.
    for (int i = 0; i < 3; i++) seq(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wait_pc", PC, 32'hC);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wait_done_pc", PC, 32'h10);

    // Redirect while waiting, consumed two cycles later, then sequential.
    seq(1'b0, 1'b0, 1'b1, 32'h100);
    seq(1'b0, 1'b0, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("redir_pc", PC, 32'h100);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("redir_next_pc", PC, 32'h104);

    // Redirect during stall.
    seq(1'b1, 1'b1, 1'b1, 32'h40);
    seq(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_pc", PC, 32'h104);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_redir_pc", PC, 32'h40);

    // Randomized traffic with aligned targets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pn;
      pn = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : (m_pc + 32'd4);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) < 3,
            $urandom_range(0, 6) == 0, $urandom() & 32'hFFFF_FFFC, pn);
    end

    // Counter wrap: preload all-ones during a stall, then one handshake.
    seq(1'b1, 1'b0, 1'b0, 32'h0);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_cnt = 32'hFFFF_FFFF;
    seq(1'b1, 1'b0, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_count", Fetch_Count, 32'd0);

    // Asynchronous reset in the middle of a memory wait.
    seq(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset();
    @(posedge clk); #1;
    chk_reset();
    rst_n = 1'b1;
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    chk("post_rst_pc", PC, 32'h4);

    // Misaligned redirect on a handshake: halt forever.
    seq(1'b0, 1'b1, 1'b1, 32'h102);
    chk("mis_pc",   PC,                       32'h4);
    chk("mis_trap", {31'd0, Trap_Misaligned}, 32'd1);
    for (int i = 0; i < 6; i++)
      cycle($urandom_range(0, 1) == 1, 1'b1, 1'b1, $urandom() & 32'hFFFF_FFFC, m_pc + 32'd4);
    chk("halt_pc",    PC,          32'h4);
    chk("halt_count", Fetch_Count, 32'd2);

    // Reset clears the halt.
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seq(1'b0, 1'b1, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
